// File: rtl/mycpu_fetch_pkg.sv
`default_nettype none
// ============================================================================
// mycpu_fetch_pkg : shared fetch constants and redirect source encoding
// Revision 1.0
// ============================================================================
package mycpu_fetch_pkg;

  localparam logic [31:0] RESET_PC = 32'h1c00_0000;
  localparam int          MAX_OUT  = 2;

  // Numeric order doubles as priority order: larger wins.
  typedef enum logic [1:0] {
    SRC_BR      = 2'd0,
    SRC_REFETCH = 2'd1,
    SRC_ERTN    = 2'd2,
    SRC_EX      = 2'd3
  } redirect_src_e;

endpackage
`default_nettype wire

// File: rtl/fetch_redirect_ctrl_if.sv
`default_nettype none
// ============================================================================
// fetch_redirect_ctrl_if : inst-SRAM-like request / response channel
// Revision 1.0
// ============================================================================
interface fetch_redirect_ctrl_if;

  logic        req_valid;
  logic [31:0] req_pc;
  logic        addr_ok;
  logic        data_ok;

  modport master (
    output req_valid,
    output req_pc,
    input  addr_ok,
    input  data_ok
  );

  modport slave (
    input  req_valid,
    input  req_pc,
    output addr_ok,
    output data_ok
  );

endinterface
`default_nettype wire

// File: rtl/fetch_redirect_ctrl_prio_sel.sv
`default_nettype none
// ============================================================================
// redirect_prio_sel : fixed-priority four-way redirect selector (ex > ertn >
// refetch > br).  Revision 1.0
// ============================================================================
module redirect_prio_sel
  import mycpu_fetch_pkg::*;
(
  input  logic          i_ex_valid,
  input  logic [31:0]   i_ex_target,
  input  logic          i_ertn_valid,
  input  logic [31:0]   i_ertn_target,
  input  logic          i_refetch_valid,
  input  logic [31:0]   i_refetch_target,
  input  logic          i_br_valid,
  input  logic [31:0]   i_br_target,
  output logic          o_valid,
  output redirect_src_e o_src,
  output logic [31:0]   o_target
);

  always_comb begin
    o_valid  = 1'b1;
    o_src    = SRC_EX;
    o_target = i_ex_target;
    if (i_ex_valid) begin
      o_src    = SRC_EX;
      o_target = i_ex_target;
    end else if (i_ertn_valid) begin
      o_src    = SRC_ERTN;
      o_target = i_ertn_target;
    end else if (i_refetch_valid) begin
      o_src    = SRC_REFETCH;
      o_target = i_refetch_target;
    end else if (i_br_valid) begin
      o_src    = SRC_BR;
      o_target = i_br_target;
    end else begin
      o_valid  = 1'b0;
      o_src    = SRC_BR;
      o_target = i_br_target;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// fetch_redirect_ctrl : PC generation, redirect arbitration and stale-response
// filtering for an inst-SRAM-like fetch port.  Revision 1.0
// ============================================================================
module fetch_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = mycpu_fetch_pkg::RESET_PC,
  parameter int          MAX_OUT  = mycpu_fetch_pkg::MAX_OUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_valid,
  input  logic [31:0]           ex_target,
  input  logic                  ertn_valid,
  input  logic [31:0]           ertn_era,
  input  logic                  refetch_valid,
  input  logic [31:0]           refetch_pc,
  input  logic                  br_valid,
  input  logic [31:0]           br_target,
  input  logic                  fetch_en,
  fetch_redirect_ctrl_if.master mem,
  output logic                  inst_valid,
  output logic                  adef
);
  import mycpu_fetch_pkg::*;

  localparam int            CW        = $clog2(MAX_OUT + 2);
  localparam logic [CW-1:0] c_max_out = CW'(MAX_OUT);
  localparam logic [CW-1:0] c_one     = CW'(1);
  localparam logic [0:0]    c_OPEN    = 1'b0;
  localparam logic [0:0]    c_HOLD    = 1'b1;

  logic [0:0]    r_state;
  logic [0:0]    w_next_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_hold_pc;
  logic          r_pend_valid;
  redirect_src_e r_pend_src;
  logic [31:0]   r_pend_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;

  logic          w_rd_valid;
  redirect_src_e w_rd_src;
  logic [31:0]   w_rd_target;
  logic [31:0]   w_open_pc;
  logic [31:0]   w_req_pc;
  logic          w_req_valid;
  logic          w_adef;
  logic          w_cur_refetch;
  logic          w_cap_ok;
  logic          w_accept;
  logic          w_ret;

  redirect_prio_sel u_prio (
    .i_ex_valid       (ex_valid),
    .i_ex_target      (ex_target),
    .i_ertn_valid     (ertn_valid),
    .i_ertn_target    (ertn_era),
    .i_refetch_valid  (refetch_valid),
    .i_refetch_target (refetch_pc),
    .i_br_valid       (br_valid),
    .i_br_target      (br_target),
    .o_valid          (w_rd_valid),
    .o_src            (w_rd_src),
    .o_target         (w_rd_target)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= c_OPEN;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_OPEN:  if (w_req_valid && !mem.addr_ok) w_next_state = c_HOLD;
      c_HOLD:  if (mem.addr_ok)                 w_next_state = c_OPEN;
      default: w_next_state = c_OPEN;
    endcase
  end

  always_comb begin
    w_open_pc     = w_rd_valid ? w_rd_target : (r_pend_valid ? r_pend_pc : r_pc);
    w_cur_refetch = w_rd_valid ? (w_rd_src == SRC_REFETCH)
                               : (r_pend_valid && (r_pend_src == SRC_REFETCH));
    w_cap_ok      = (r_outstanding < c_max_out) ||
                    ((r_outstanding == c_max_out) && mem.data_ok);
    w_req_pc      = (r_state == c_HOLD) ? r_hold_pc : w_open_pc;
    w_adef        = (w_req_pc[1:0] != 2'b00);
    if (reset)                  w_req_valid = 1'b0;
    else if (r_state == c_HOLD) w_req_valid = 1'b1;
    else                        w_req_valid = fetch_en && !w_adef && w_cap_ok && !w_cur_refetch;
    w_accept      = w_req_valid && mem.addr_ok;
    w_ret         = mem.data_ok && (r_outstanding != '0);
  end

  assign mem.req_valid = w_req_valid;
  assign mem.req_pc    = reset ? RESET_PC : w_req_pc;
  assign adef          = !reset && w_adef;
  assign inst_valid    = !reset && w_ret && (r_discard == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_hold_pc     <= RESET_PC;
      r_pend_valid  <= 1'b0;
      r_pend_src    <= SRC_BR;
      r_pend_pc     <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      if (r_state == c_OPEN && w_req_valid) r_hold_pc <= w_req_pc;
      if (w_accept) r_pc <= w_req_pc + 32'd4;

      // Issuing from OPEN consumes the pending target (accepted or now held).
      if (r_state == c_OPEN && w_req_valid) begin
        r_pend_valid <= 1'b0;
      end else if (w_rd_valid && (!r_pend_valid || (w_rd_src >= r_pend_src))) begin
        r_pend_valid <= 1'b1;
        r_pend_src   <= w_rd_src;
        r_pend_pc    <= w_rd_target;
      end

      case ({w_accept, w_ret})
        2'b10:   r_outstanding <= r_outstanding + c_one;
        2'b01:   r_outstanding <= r_outstanding - c_one;
        default: r_outstanding <= r_outstanding;
      endcase

      // A response returning in the redirect cycle is already accounted for.
      if (w_rd_valid)
        r_discard <= r_outstanding - CW'(w_ret) + CW'(r_state == c_HOLD);
      else if (w_ret && (r_discard != '0))
        r_discard <= r_discard - c_one;
    end
  end

endmodule
`default_nettype wire
